// File: rtl/cva6_pma_pkg.sv
// Shared types and constants for the runtime-programmable PMA table.
package cva6_pma_pkg;

    localparam int unsigned AttrWidth = 8;
    localparam int unsigned PermWidth = 3;

    localparam int unsigned AttrBitX  = 0;
    localparam int unsigned AttrBitC  = 1;
    localparam int unsigned AttrBitNI = 2;
    localparam int unsigned AttrBitL  = 7;

    typedef struct packed {
        logic       l;
        logic [3:0] rsvd;
        logic       ni;
        logic       c;
        logic       x;
    } pma_attr_t;

    typedef enum logic [1:0] {
        PMA_BASE   = 2'd0,
        PMA_LENGTH = 2'd1,
        PMA_ATTR   = 2'd2,
        PMA_RSVD   = 2'd3
    } pma_field_e;

    // Unmatched addresses are treated as non-idempotent, non-executable, uncached.
    localparam pma_attr_t PmaMissAttr = pma_attr_t'(8'h04);

endpackage

// File: rtl/cva6_pma_match.sv
// Combinational address-vs-rules matcher; the lowest-index enabled rule wins.
module cva6_pma_match
    import cva6_pma_pkg::*;
#(
    parameter int unsigned NrRules   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned IdxW      = 2
) (
    input  logic [AddrWidth-1:0]                addr,
    input  logic [NrRules-1:0][AddrWidth-1:0]   base,
    input  logic [NrRules-1:0][AddrWidth-1:0]   length,
    input  logic [NrRules-1:0][PermWidth-1:0]   perm,
    output logic                                hit_c,
    output logic [IdxW-1:0]                     idx_c,
    output logic [PermWidth-1:0]                perm_c
);

    logic [NrRules-1:0] in_range;

    // Limit is one bit wider so a range can never wrap past the top of memory.
    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        logic [AddrWidth:0] limit;
        assign limit       = {1'b0, base[g]} + {1'b0, length[g]};
        assign in_range[g] = (length[g] != '0) && (addr >= base[g]) && ({1'b0, addr} < limit);
    end

    always_comb begin
        hit_c  = 1'b0;
        idx_c  = '0;
        perm_c = PmaMissAttr[PermWidth-1:0];
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (!hit_c && in_range[i]) begin
                hit_c  = 1'b1;
                idx_c  = IdxW'(i);
                perm_c = perm[i];
            end
        end
    end

endmodule

// File: rtl/cva6_pma_table.sv
// Programmable PMA rule table with a config port and a one-cycle registered lookup port.
module cva6_pma_table
    import cva6_pma_pkg::*;
#(
    parameter int unsigned NrRules   = 4,
    parameter int unsigned AddrWidth = 64,
    parameter logic [NrRules*AddrWidth-1:0] RstBase =
        {64'h0, 64'h0, 64'h1_0000, 64'h8000_0000},
    parameter logic [NrRules*AddrWidth-1:0] RstLength =
        {64'h0, 64'h1000, 64'h1_0000, 64'h4000_0000},
    parameter logic [NrRules*AttrWidth-1:0] RstAttr =
        {8'h00, 8'h01, 8'h01, 8'h03},
    localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [1:0]           cfg_field_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lookup_valid_i,
    output logic                 lookup_ready_o,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic                 resp_match_o,
    output logic [IdxW-1:0]      resp_idx_o,
    output logic                 resp_exec_o,
    output logic                 resp_cached_o,
    output logic                 resp_nonidem_o
);

    logic [NrRules-1:0][AddrWidth-1:0] base_q;
    logic [NrRules-1:0][AddrWidth-1:0] length_q;
    pma_attr_t [NrRules-1:0]           attr_q;
    logic [NrRules-1:0][PermWidth-1:0] perm;

    pma_field_e           cfg_field;
    logic                 cfg_idx_ok;
    logic [IdxW-1:0]      cfg_idx_safe;
    logic                 cfg_err;
    logic                 cfg_wr_en;
    logic [AddrWidth-1:0] cfg_rdata;

    logic                 match_hit;
    logic [IdxW-1:0]      match_idx;
    logic [PermWidth-1:0] match_perm;
    logic                 lookup_accept;

    assign cfg_field  = pma_field_e'(cfg_field_i);
    assign cfg_idx_ok = 32'(cfg_idx_i) < NrRules;

    // Config decode: error qualification and read mux, evaluated on the request cycle.
    always_comb begin
        cfg_idx_safe = cfg_idx_ok ? cfg_idx_i : '0;
        cfg_err      = !cfg_idx_ok || (cfg_field == PMA_RSVD) ||
                       (cfg_we_i && attr_q[cfg_idx_safe][AttrBitL]);
        cfg_rdata    = '0;
        case (cfg_field)
            PMA_BASE:   cfg_rdata = base_q[cfg_idx_safe];
            PMA_LENGTH: cfg_rdata = length_q[cfg_idx_safe];
            PMA_ATTR:   cfg_rdata = {{(AddrWidth-AttrWidth){1'b0}}, attr_q[cfg_idx_safe]};
            default:    cfg_rdata = '0;
        endcase
        if (cfg_err) begin
            cfg_rdata = '0;
        end
    end

    assign cfg_wr_en = cfg_req_i && cfg_we_i && !cfg_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                base_q[i]   <= RstBase[i*AddrWidth +: AddrWidth];
                length_q[i] <= RstLength[i*AddrWidth +: AddrWidth];
                attr_q[i]   <= pma_attr_t'(RstAttr[i*AttrWidth +: AttrWidth]);
            end
        end else if (cfg_wr_en) begin
            case (cfg_field)
                PMA_BASE:   base_q[cfg_idx_safe]   <= cfg_wdata_i;
                PMA_LENGTH: length_q[cfg_idx_safe] <= cfg_wdata_i;
                PMA_ATTR:   attr_q[cfg_idx_safe]   <= pma_attr_t'(cfg_wdata_i[AttrWidth-1:0]);
                default:    ;
            endcase
        end
    end

    // Config completion, exactly one cycle after every request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_rvalid_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            cfg_err_o    <= cfg_req_i && cfg_err;
            cfg_rdata_o  <= (cfg_req_i && !cfg_we_i) ? cfg_rdata : '0;
        end
    end

    for (genvar g = 0; g < NrRules; g++) begin : g_perm
        assign perm[g] = {attr_q[g].ni, attr_q[g].c, attr_q[g].x};
    end

    cva6_pma_match #(
        .NrRules   (NrRules),
        .AddrWidth (AddrWidth),
        .IdxW      (IdxW)
    ) u_match (
        .addr   (lookup_addr_i),
        .base   (base_q),
        .length (length_q),
        .perm   (perm),
        .hit_c  (match_hit),
        .idx_c  (match_idx),
        .perm_c (match_perm)
    );

    assign lookup_ready_o = !resp_valid_o || resp_ready_i;
    assign lookup_accept  = lookup_valid_i && lookup_ready_o;

    // Response register: loads on accept, holds while stalled, clears valid when drained.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_o   <= 1'b0;
            resp_match_o   <= 1'b0;
            resp_idx_o     <= '0;
            resp_exec_o    <= 1'b0;
            resp_cached_o  <= 1'b0;
            resp_nonidem_o <= 1'b0;
        end else if (lookup_accept) begin
            resp_valid_o   <= 1'b1;
            resp_match_o   <= match_hit;
            resp_idx_o     <= match_idx;
            resp_exec_o    <= match_perm[AttrBitX];
            resp_cached_o  <= match_perm[AttrBitC];
            resp_nonidem_o <= match_perm[AttrBitNI];
        end else if (resp_ready_i) begin
            resp_valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cva6_pma_table.sv
// Directed, table-driven bench for cva6_pma_table with hand-written stall and reset sequences.
module tb_cva6_pma_table;

    localparam int K_LOOK = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    typedef struct {
        int          kind;
        logic [1:0]  idx;
        logic [1:0]  field;
        logic [63:0] data;
        logic        exp_err;
        logic [63:0] exp_rdata;
        logic        exp_match;
        logic [1:0]  exp_idx;
        logic [2:0]  exp_nicx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        cfg_req_i, cfg_we_i;
    logic [1:0]  cfg_idx_i, cfg_field_i;
    logic [63:0] cfg_wdata_i;
    logic        cfg_rvalid_o, cfg_err_o;
    logic [63:0] cfg_rdata_o;
    logic        lookup_valid_i, lookup_ready_o;
    logic [63:0] lookup_addr_i;
    logic        resp_valid_o, resp_ready_i, resp_match_o;
    logic [1:0]  resp_idx_o;
    logic        resp_exec_o, resp_cached_o, resp_nonidem_o;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    cva6_pma_table dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cfg_req_i      (cfg_req_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_idx_i      (cfg_idx_i),
        .cfg_field_i    (cfg_field_i),
        .cfg_wdata_i    (cfg_wdata_i),
        .cfg_rvalid_o   (cfg_rvalid_o),
        .cfg_rdata_o    (cfg_rdata_o),
        .cfg_err_o      (cfg_err_o),
        .lookup_valid_i (lookup_valid_i),
        .lookup_ready_o (lookup_ready_o),
        .lookup_addr_i  (lookup_addr_i),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .resp_match_o   (resp_match_o),
        .resp_idx_o     (resp_idx_o),
        .resp_exec_o    (resp_exec_o),
        .resp_cached_o  (resp_cached_o),
        .resp_nonidem_o (resp_nonidem_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int kind, input logic [1:0] idx, input logic [1:0] field,
                                input logic [63:0] data, input logic err, input logic [63:0] rd,
                                input logic m, input logic [1:0] ei, input logic [2:0] nicx);
        vec_t v;
        v.kind = kind;  v.idx = idx;  v.field = field;  v.data = data;
        v.exp_err = err;  v.exp_rdata = rd;
        v.exp_match = m;  v.exp_idx = ei;  v.exp_nicx = nicx;
        return v;
    endfunction

    task automatic check_resp(input string nm, input logic m, input logic [1:0] ei,
                              input logic [2:0] nicx);
        chk({nm, " resp_valid"},   64'(resp_valid_o),   64'd1);
        chk({nm, " resp_match"},   64'(resp_match_o),   64'(m));
        chk({nm, " resp_idx"},     64'(resp_idx_o),     64'(ei));
        chk({nm, " resp_exec"},    64'(resp_exec_o),    64'(nicx[0]));
        chk({nm, " resp_cached"},  64'(resp_cached_o),  64'(nicx[1]));
        chk({nm, " resp_nonidem"}, 64'(resp_nonidem_o), 64'(nicx[2]));
    endtask

    // One request cycle followed by a check of its completion one cycle later.
    task automatic apply_vec(input vec_t v, input string nm);
        @(negedge clk);
        cfg_req_i      = (v.kind != K_LOOK);
        cfg_we_i       = (v.kind == K_WR);
        cfg_idx_i      = v.idx;
        cfg_field_i    = v.field;
        cfg_wdata_i    = v.data;
        lookup_valid_i = (v.kind == K_LOOK);
        lookup_addr_i  = v.data;
        @(posedge clk);
        #1;
        if (v.kind == K_LOOK) begin
            check_resp(nm, v.exp_match, v.exp_idx, v.exp_nicx);
            chk({nm, " cfg_rvalid"}, 64'(cfg_rvalid_o), 64'd0);
        end else begin
            chk({nm, " cfg_rvalid"}, 64'(cfg_rvalid_o), 64'd1);
            chk({nm, " cfg_err"},    64'(cfg_err_o),    64'(v.exp_err));
            chk({nm, " cfg_rdata"},  cfg_rdata_o,       v.exp_rdata);
            chk({nm, " resp_valid"}, 64'(resp_valid_o), 64'd0);
        end
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        cfg_req_i      = 1'b0;
        cfg_we_i       = 1'b0;
        lookup_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;  cfg_req_i = 1'b0;  cfg_we_i = 1'b0;  cfg_idx_i = '0;  cfg_field_i = '0;
        cfg_wdata_i = '0;  lookup_valid_i = 1'b0;  lookup_addr_i = '0;  resp_ready_i = 1'b1;

        // kind, idx, field, data, err, rdata, match, idx, {NI,C,X}
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h8000_1000,          0, 0,        1, 0, 3'b011));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h0000_0800,          0, 0,        1, 2, 3'b001));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'hBFFF_FFFF,          0, 0,        1, 0, 3'b011));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'hC000_0000,          0, 0,        0, 0, 3'b100));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h0001_8000,          0, 0,        1, 1, 3'b001));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h0000_1000,          0, 0,        0, 0, 3'b100));
        vecs.push_back(mk(K_WR,   3, 0, 64'h4000_0000,          0, 0,        0, 0, 0));
        vecs.push_back(mk(K_WR,   3, 1, 64'h1000,               0, 0,        0, 0, 0));
        vecs.push_back(mk(K_WR,   3, 2, 64'h04,                 0, 0,        0, 0, 0));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h4000_0800,          0, 0,        1, 3, 3'b100));
        vecs.push_back(mk(K_RD,   3, 2, 0,                      0, 64'h04,   0, 0, 0));
        vecs.push_back(mk(K_WR,   1, 2, 64'h81,                 0, 0,        0, 0, 0));
        vecs.push_back(mk(K_WR,   1, 0, 64'h2000,               1, 0,        0, 0, 0));
        vecs.push_back(mk(K_RD,   1, 0, 0,                      0, 64'h1_0000, 0, 0, 0));
        vecs.push_back(mk(K_RD,   1, 2, 0,                      0, 64'h81,   0, 0, 0));
        vecs.push_back(mk(K_WR,   0, 3, 64'h5,                  1, 0,        0, 0, 0));
        vecs.push_back(mk(K_RD,   0, 3, 0,                      1, 0,        0, 0, 0));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h0001_0000,          0, 0,        1, 1, 3'b001));
        vecs.push_back(mk(K_WR,   3, 2, 64'h78,                 0, 0,        0, 0, 0));
        vecs.push_back(mk(K_RD,   3, 2, 0,                      0, 64'h78,   0, 0, 0));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h4000_0FFF,          0, 0,        1, 3, 3'b000));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h4000_1000,          0, 0,        0, 0, 3'b100));
        vecs.push_back(mk(K_WR,   3, 0, 64'hFFFF_FFFF_FFFF_F000, 0, 0,       0, 0, 0));
        vecs.push_back(mk(K_WR,   3, 1, 64'h2000,               0, 0,        0, 0, 0));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0,       1, 3, 3'b000));
        vecs.push_back(mk(K_LOOK, 0, 0, 64'h0,                  0, 0,        1, 2, 3'b001));
        vecs.push_back(mk(K_RD,   3, 1, 0,                      0, 64'h2000, 0, 0, 0));
        vecs.push_back(mk(K_RD,   0, 0, 0,                      0, 64'h8000_0000, 0, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("reset resp_valid",   64'(resp_valid_o),   64'd0);
        chk("reset lookup_ready", 64'(lookup_ready_o), 64'd1);
        chk("reset cfg_rvalid",   64'(cfg_rvalid_o),   64'd0);
        chk("reset cfg_err",      64'(cfg_err_o),      64'd0);
        chk("reset cfg_rdata",    cfg_rdata_o,         64'd0);
        chk("reset resp_match",   64'(resp_match_o),   64'd0);
        chk("reset resp_nonidem", 64'(resp_nonidem_o), 64'd0);

        foreach (vecs[n]) apply_vec(vecs[n], $sformatf("v%0d", n));
        idle_inputs();

        // Same-cycle write and lookup: lookup sees the old rule 2, the next one the new.
        @(negedge clk);
        cfg_req_i = 1'b1;  cfg_we_i = 1'b1;  cfg_idx_i = 2;  cfg_field_i = 1;  cfg_wdata_i = 64'h0;
        lookup_valid_i = 1'b1;  lookup_addr_i = 64'h800;
        @(posedge clk);
        #1;
        check_resp("same-cycle old", 1'b1, 2'd2, 3'b001);
        chk("same-cycle cfg_err", 64'(cfg_err_o), 64'd0);
        apply_vec(mk(K_LOOK, 0, 0, 64'h800, 0, 0, 0, 0, 3'b100), "next-cycle new");
        idle_inputs();

        // Back-pressure: three stalled cycles, then drain one response per cycle in order.
        @(negedge clk);
        resp_ready_i = 1'b0;  lookup_valid_i = 1'b1;  lookup_addr_i = 64'h8000_0000;
        @(posedge clk);
        #1;
        check_resp("bp r0", 1'b1, 2'd0, 3'b011);
        chk("bp ready low", 64'(lookup_ready_o), 64'd0);
        @(negedge clk);
        lookup_addr_i = 64'h0001_0000;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_resp($sformatf("bp hold%0d", k), 1'b1, 2'd0, 3'b011);
            chk($sformatf("bp hold%0d ready", k), 64'(lookup_ready_o), 64'd0);
        end
        @(negedge clk);
        resp_ready_i = 1'b1;
        #1;
        chk("bp release ready", 64'(lookup_ready_o), 64'd1);
        @(posedge clk);
        #1;
        check_resp("bp r1", 1'b1, 2'd1, 3'b001);
        @(negedge clk);
        lookup_addr_i = 64'hFFFF_FFFF_FFFF_F800;
        @(posedge clk);
        #1;
        check_resp("bp r2", 1'b1, 2'd3, 3'b000);
        @(negedge clk);
        lookup_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("bp drained", 64'(resp_valid_o), 64'd0);

        // Reset with a stalled response and a config request in flight.
        @(negedge clk);
        resp_ready_i = 1'b0;  lookup_valid_i = 1'b1;  lookup_addr_i = 64'h8000_0000;
        @(posedge clk);
        #1;
        chk("pre-reset resp_valid", 64'(resp_valid_o), 64'd1);
        @(negedge clk);
        rst_i = 1'b1;  lookup_valid_i = 1'b0;
        cfg_req_i = 1'b1;  cfg_we_i = 1'b0;  cfg_idx_i = 1;  cfg_field_i = 2;
        @(posedge clk);
        #1;
        chk("mid-reset resp_valid",   64'(resp_valid_o),   64'd0);
        chk("mid-reset cfg_rvalid",   64'(cfg_rvalid_o),   64'd0);
        chk("mid-reset lookup_ready", 64'(lookup_ready_o), 64'd1);
        @(negedge clk);
        rst_i = 1'b0;  cfg_req_i = 1'b0;  resp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset cfg_rvalid", 64'(cfg_rvalid_o), 64'd0);
        apply_vec(mk(K_RD,   3, 0, 0, 0, 64'h0,    0, 0, 0), "rst r3 base");
        apply_vec(mk(K_RD,   3, 1, 0, 0, 64'h0,    0, 0, 0), "rst r3 len");
        apply_vec(mk(K_RD,   1, 2, 0, 0, 64'h01,   0, 0, 0), "rst r1 attr");
        apply_vec(mk(K_RD,   2, 1, 0, 0, 64'h1000, 0, 0, 0), "rst r2 len");
        apply_vec(mk(K_LOOK, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, 0, 3'b100), "rst top miss");
        apply_vec(mk(K_WR,   1, 0, 64'h2000, 0, 0, 0, 0, 0), "rst r1 unlocked");
        apply_vec(mk(K_RD,   1, 0, 0, 0, 64'h2000, 0, 0, 0), "rst r1 base new");
        idle_inputs();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
